// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: N-phase traffic signal controller with pedestrian WALK service.
//
// Cycles ALLRED -> GREEN -> YELLOW -> ALLRED, serving one phase per GREEN. In fixed mode
// (ACTUATED=0) phases are served round-robin. In actuated mode (ACTUATED=1) idle phases
// are skipped, and the served phase rests in green until another phase requests service.
// All outputs are registered.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   veh_req    per-phase level vehicle-presence sensor
//   ped_req    per-phase pedestrian button; a 1-cycle pulse is latched
//   green      per-phase green lamp
//   yellow     per-phase yellow lamp
//   red        per-phase red lamp
//   walk       per-phase WALK lamp
//   ped_wait   OR of all pending pedestrian latches
//   phase_idx  current (or last served) phase
module traffic_ctrl_multi #(
    parameter int unsigned N_PHASES = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned PED_T    = 5,
    parameter int unsigned ACTUATED = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PHASES-1:0]         veh_req,
    input  logic [N_PHASES-1:0]         ped_req,
    output logic [N_PHASES-1:0]         green,
    output logic [N_PHASES-1:0]         yellow,
    output logic [N_PHASES-1:0]         red,
    output logic [N_PHASES-1:0]         walk,
    output logic                        ped_wait,
    output logic [$clog2(N_PHASES)-1:0] phase_idx
);

    localparam int unsigned PW        = $clog2(N_PHASES);
    localparam int unsigned GRN_PED_T = (GREEN_T > PED_T) ? GREEN_T : PED_T;

    // Timer reload values: a state lasting T cycles loads T-1.
    localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] GRN_PED_LD = CNT_W'(GRN_PED_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LD     = CNT_W'(PED_T - 1);

    localparam logic [PW-1:0] LAST_PH = PW'(N_PHASES - 1);

    localparam logic [1:0] S_ALLRED = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    walk_cnt_q, walk_cnt_d;
    logic [PW-1:0]       cur_q, cur_d;
    logic [N_PHASES-1:0] latch_q, latch_d;
    logic [N_PHASES-1:0] green_q, green_d;
    logic [N_PHASES-1:0] yellow_q, yellow_d;
    logic [N_PHASES-1:0] red_q, red_d;
    logic [N_PHASES-1:0] walk_q, walk_d;
    logic                ped_wait_q;

    logic [N_PHASES-1:0] req_v;
    logic [N_PHASES-1:0] cur_oh;
    logic                other_req;
    logic [PW-1:0]       rr_next;
    logic [PW-1:0]       next_ph;
    logic [PW-1:0]       scan_p;
    logic                found;

    // Next-phase selection; actuated mode scans from cur+1 and checks cur itself last.
    always_comb begin
        req_v         = veh_req | latch_q;
        cur_oh        = '0;
        cur_oh[cur_q] = 1'b1;
        other_req     = |(req_v & ~cur_oh);
        rr_next       = (cur_q == LAST_PH) ? '0 : cur_q + 1'b1;
        next_ph       = rr_next;
        found         = 1'b0;
        scan_p        = cur_q;
        if (ACTUATED != 0) begin
            for (int unsigned k = 0; k < N_PHASES; k++) begin
                scan_p = (scan_p == LAST_PH) ? '0 : scan_p + 1'b1;
                if (!found && req_v[scan_p]) begin
                    found   = 1'b1;
                    next_ph = scan_p;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        walk_cnt_d = walk_cnt_q;
        cur_d      = cur_q;
        green_d    = green_q;
        yellow_d   = yellow_q;
        red_d      = red_q;
        walk_d     = walk_q;
        latch_d    = latch_q | ped_req;

        if (|walk_q) begin
            if (walk_cnt_q == '0) begin
                walk_d = '0;
            end else begin
                walk_cnt_d = walk_cnt_q - 1'b1;
            end
        end

        case (state_q)
            S_ALLRED: begin
                if (timer_q == '0) begin
                    state_d          = S_GREEN;
                    cur_d            = next_ph;
                    green_d          = '0;
                    green_d[next_ph] = 1'b1;
                    red_d            = '1;
                    red_d[next_ph]   = 1'b0;
                    walk_d           = '0;
                    if (latch_q[next_ph]) begin
                        // Clearing here discards a ped_req arriving on this same edge.
                        latch_d[next_ph] = 1'b0;
                        walk_d[next_ph]  = 1'b1;
                        walk_cnt_d       = PED_LD;
                        timer_d          = GRN_PED_LD;
                    end else begin
                        timer_d = GREEN_LD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GREEN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if ((ACTUATED == 0) || other_req) begin
                    state_d  = S_YELLOW;
                    yellow_d = green_q;
                    green_d  = '0;
                    walk_d   = '0;
                    timer_d  = YELLOW_LD;
                end else if (latch_q[cur_q]) begin
                    // Resting phase serves its own pedestrian: the timer reload pins
                    // green until the restarted walk has finished.
                    latch_d[cur_q] = 1'b0;
                    walk_d         = cur_oh;
                    walk_cnt_d     = PED_LD;
                    timer_d        = PED_LD;
                end
            end
            S_YELLOW: begin
                if (timer_q == '0) begin
                    state_d  = S_ALLRED;
                    yellow_d = '0;
                    red_d    = '1;
                    timer_d  = ALLRED_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d  = S_ALLRED;
                green_d  = '0;
                yellow_d = '0;
                red_d    = '1;
                walk_d   = '0;
                timer_d  = ALLRED_LD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_ALLRED;
            timer_q    <= ALLRED_LD;
            walk_cnt_q <= '0;
            cur_q      <= LAST_PH;
            latch_q    <= '0;
            green_q    <= '0;
            yellow_q   <= '0;
            red_q      <= '1;
            walk_q     <= '0;
            ped_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            walk_cnt_q <= walk_cnt_d;
            cur_q      <= cur_d;
            latch_q    <= latch_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
            walk_q     <= walk_d;
            ped_wait_q <= |latch_d;
        end
    end

    assign green     = green_q;
    assign yellow    = yellow_q;
    assign red       = red_q;
    assign walk      = walk_q;
    assign ped_wait  = ped_wait_q;
    assign phase_idx = cur_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Testbench for traffic_ctrl_multi: three instances (fixed, actuated PED_T=5,
// actuated PED_T=12) share vehicle/pedestrian inputs and have separate resets.
module tb_traffic_ctrl_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v;
    logic [3:0] veh;
    logic [3:0] ped;
    logic [3:0] g_o [3];
    logic [3:0] y_o [3];
    logic [3:0] r_o [3];
    logic [3:0] w_o [3];
    logic       pw_o [3];
    logic [1:0] ph_o [3];

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    traffic_ctrl_multi #(.N_PHASES(4), .CNT_W(8), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2),
                         .PED_T(5), .ACTUATED(0)) u_fix (
        .clk(clk), .rst(rst_v[0]), .veh_req(veh), .ped_req(ped),
        .green(g_o[0]), .yellow(y_o[0]), .red(r_o[0]), .walk(w_o[0]),
        .ped_wait(pw_o[0]), .phase_idx(ph_o[0])
    );

    traffic_ctrl_multi #(.N_PHASES(4), .CNT_W(8), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2),
                         .PED_T(5), .ACTUATED(1)) u_act (
        .clk(clk), .rst(rst_v[1]), .veh_req(veh), .ped_req(ped),
        .green(g_o[1]), .yellow(y_o[1]), .red(r_o[1]), .walk(w_o[1]),
        .ped_wait(pw_o[1]), .phase_idx(ph_o[1])
    );

    traffic_ctrl_multi #(.N_PHASES(4), .CNT_W(8), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2),
                         .PED_T(12), .ACTUATED(1)) u_act12 (
        .clk(clk), .rst(rst_v[2]), .veh_req(veh), .ped_req(ped),
        .green(g_o[2]), .yellow(y_o[2]), .red(r_o[2]), .walk(w_o[2]),
        .ped_wait(pw_o[2]), .phase_idx(ph_o[2])
    );

    // One record: drive veh/ped for edge edge_n, then expect these outputs after it.
    typedef struct {
        int         edge_n;
        logic [3:0] veh;
        logic [3:0] ped;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic [3:0] w;
        logic       pw;
        logic [1:0] ph;
    } vec_t;

    vec_t tab[$];
    vec_t rst_exp;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int d, input string tag, input vec_t v);
        chk({tag, " green"}, {4'h0, g_o[d]}, {4'h0, v.g});
        chk({tag, " yellow"}, {4'h0, y_o[d]}, {4'h0, v.y});
        chk({tag, " red"}, {4'h0, r_o[d]}, {4'h0, v.r});
        chk({tag, " walk"}, {4'h0, w_o[d]}, {4'h0, v.w});
        chk({tag, " ped_wait"}, {7'h0, pw_o[d]}, {7'h0, v.pw});
        chk({tag, " phase_idx"}, {6'h0, ph_o[d]}, {6'h0, v.ph});
    endtask

    // Exactly one lamp per phase, at most one non-red phase.
    task automatic inv(input int d);
        logic [3:0] g, y, r;
        logic       ok;
        g  = g_o[d];
        y  = y_o[d];
        r  = r_o[d];
        ok = ((g | y | r) == 4'hF) && ((g & y) == 4'h0) && ((g & r) == 4'h0) &&
             ((y & r) == 4'h0) && ($countones(g | y) <= 1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lamp invariant dut%0d e%0d: got g=%b y=%b r=%b required one-hot",
                     d, ecnt, g, y, r);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ecnt++;
    endtask

    task automatic release_rst(input int d);
        @(negedge clk);
        rst_v[d] = 1'b1;
        ecnt     = 0;
    endtask

    task automatic run_tab(input int d, input string name);
        foreach (tab[i]) begin
            while (ecnt < tab[i].edge_n - 1) begin
                ped = 4'h0;
                tick();
                inv(d);
            end
            veh = tab[i].veh;
            ped = tab[i].ped;
            tick();
            ped = 4'h0;
            inv(d);
            check_out(d, $sformatf("%s e%0d", name, tab[i].edge_n), tab[i]);
        end
    endtask

    initial begin
        rst_v   = 3'b000;
        veh     = 4'h0;
        ped     = 4'h0;
        rst_exp = '{0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 2'd3};
        repeat (3) @(negedge clk);

        // Fixed mode: plain round-robin plus a pedestrian pulse for phase 2.
        release_rst(0);
        check_out(0, "fix reset", rst_exp);
        tab.delete();
        tab.push_back('{1,  4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 2'd3});
        tab.push_back('{2,  4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b0, 2'd0});
        tab.push_back('{4,  4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b0, 2'd0});
        tab.push_back('{5,  4'h0, 4'h4, 4'h1, 4'h0, 4'hE, 4'h0, 1'b1, 2'd0});
        tab.push_back('{9,  4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b1, 2'd0});
        tab.push_back('{10, 4'h0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 1'b1, 2'd0});
        tab.push_back('{12, 4'h0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 1'b1, 2'd0});
        tab.push_back('{13, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 2'd0});
        tab.push_back('{14, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 2'd0});
        tab.push_back('{15, 4'h0, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b1, 2'd1});
        tab.push_back('{27, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 2'd1});
        tab.push_back('{28, 4'h0, 4'h0, 4'h4, 4'h0, 4'hB, 4'h4, 1'b0, 2'd2});
        tab.push_back('{32, 4'h0, 4'h0, 4'h4, 4'h0, 4'hB, 4'h4, 1'b0, 2'd2});
        tab.push_back('{33, 4'h0, 4'h0, 4'h4, 4'h0, 4'hB, 4'h0, 1'b0, 2'd2});
        tab.push_back('{35, 4'h0, 4'h0, 4'h4, 4'h0, 4'hB, 4'h0, 1'b0, 2'd2});
        tab.push_back('{36, 4'h0, 4'h0, 4'h0, 4'h4, 4'hB, 4'h0, 1'b0, 2'd2});
        tab.push_back('{41, 4'h0, 4'h0, 4'h8, 4'h0, 4'h7, 4'h0, 1'b0, 2'd3});
        tab.push_back('{53, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 2'd3});
        tab.push_back('{54, 4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b0, 2'd0});
        run_tab(0, "fix");

        // Asynchronous reset in the middle of phase 2 yellow with a latch pending.
        rst_v[0] = 1'b0;
        tick();
        release_rst(0);
        tab.delete();
        tab.push_back('{2,  4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b0, 2'd0});
        tab.push_back('{35, 4'h0, 4'h0, 4'h4, 4'h0, 4'hB, 4'h0, 1'b0, 2'd2});
        tab.push_back('{36, 4'h0, 4'h8, 4'h0, 4'h4, 4'hB, 4'h0, 1'b1, 2'd2});
        run_tab(0, "rstmid");
        #2 rst_v[0] = 1'b0;
        #1 check_out(0, "async reset", rst_exp);
        release_rst(0);
        tab.delete();
        tab.push_back('{1,  4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 2'd3});
        tab.push_back('{2,  4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b0, 2'd0});
        tab.push_back('{10, 4'h0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 1'b0, 2'd0});
        run_tab(0, "after rst");
        rst_v[0] = 1'b0;

        // Actuated, PED_T=12: rest on phase 1, skip phase 2, long walk on phase 3.
        veh = 4'b0010;
        release_rst(2);
        tab.delete();
        tab.push_back('{2,  4'h2, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b0, 2'd1});
        tab.push_back('{9,  4'h2, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b0, 2'd1});
        tab.push_back('{30, 4'h2, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b0, 2'd1});
        tab.push_back('{31, 4'hA, 4'h8, 4'h0, 4'h2, 4'hD, 4'h0, 1'b1, 2'd1});
        tab.push_back('{33, 4'hA, 4'h0, 4'h0, 4'h2, 4'hD, 4'h0, 1'b1, 2'd1});
        tab.push_back('{35, 4'hA, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 2'd1});
        tab.push_back('{36, 4'hA, 4'h0, 4'h8, 4'h0, 4'h7, 4'h8, 1'b0, 2'd3});
        tab.push_back('{47, 4'hA, 4'h0, 4'h8, 4'h0, 4'h7, 4'h8, 1'b0, 2'd3});
        tab.push_back('{48, 4'hA, 4'h0, 4'h0, 4'h8, 4'h7, 4'h0, 1'b0, 2'd3});
        run_tab(2, "act12");
        rst_v[2] = 1'b0;

        // Actuated, PED_T=5: own-phase ped restart while resting holds off yellow.
        veh = 4'b0010;
        release_rst(1);
        tab.delete();
        tab.push_back('{2,  4'h2, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b0, 2'd1});
        tab.push_back('{19, 4'h2, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b0, 2'd1});
        tab.push_back('{20, 4'h2, 4'h2, 4'h2, 4'h0, 4'hD, 4'h0, 1'b1, 2'd1});
        tab.push_back('{21, 4'h2, 4'h0, 4'h2, 4'h0, 4'hD, 4'h2, 1'b0, 2'd1});
        tab.push_back('{23, 4'h3, 4'h0, 4'h2, 4'h0, 4'hD, 4'h2, 1'b0, 2'd1});
        tab.push_back('{25, 4'h3, 4'h0, 4'h2, 4'h0, 4'hD, 4'h2, 1'b0, 2'd1});
        tab.push_back('{26, 4'h3, 4'h0, 4'h0, 4'h2, 4'hD, 4'h0, 1'b0, 2'd1});
        tab.push_back('{30, 4'h3, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 2'd1});
        tab.push_back('{31, 4'h3, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b0, 2'd0});
        run_tab(1, "act5");
        rst_v[1] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
